// File: rtl/pipe_pkg.sv
// Shared constants, types and helpers for the pipelined operand-select mux.
package pipe_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEPTH_MAX    = 4;
    localparam int unsigned N_INPUTS_MIN = 2;
    localparam int unsigned N_INPUTS_MAX = 16;

    // Minimum select width able to address n inputs.
    function automatic int unsigned SEL_W_OF(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One pipeline slice; the flattened stage vectors in the RTL use this bit order.
    typedef struct packed {
        logic                 valid;
        logic                 squash;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Single pipeline slice: {valid, squash, data} register with stall hold and flush invalidate.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH+1:0] up,
    output logic [WIDTH+1:0] q
);

    // Flush beats stall; flush clears only the control bits and leaves data alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= {2'b00, q[WIDTH-1:0]};
        end else if (!stall) begin
            q <= up;
        end
    end

endmodule

// File: rtl/pipe_select_mux.sv
// N:1 operand-select mux with X/bad-select squash, feeding a DEPTH-stage stall/flush
// pipeline, plus a sticky saturating count of squashed accepted beats.
module pipe_select_mux
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DEPTH    = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [SEL_W-1:0]          sel,
    input  logic [N_INPUTS*WIDTH-1:0] data_in,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      cnt_clr,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_squash,
    output logic [CNT_W-1:0]          err_count
);

    localparam int unsigned STAGE_W = WIDTH + 2;

    logic [WIDTH-1:0] pick_c;
    logic             bad_sel_c;
    logic             squash_c;
    logic [WIDTH-1:0] mux_data_c;
    logic             accept_c;

    logic [DEPTH:0][STAGE_W-1:0] chain;

    // Only the addressed input is copied, so X on unselected inputs never reaches the checks.
    always_comb begin
        pick_c     = '0;
        bad_sel_c  = 1'b0;
        squash_c   = 1'b0;
        mux_data_c = '0;

        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            if (32'(sel) == 32'(k)) begin
                pick_c = data_in[k*WIDTH +: WIDTH];
            end
        end

        bad_sel_c = (32'(sel) >= N_INPUTS);
        squash_c  = bad_sel_c;
`ifndef SYNTHESIS
        if ($isunknown(sel) || $isunknown(pick_c)) begin
            squash_c = 1'b1;
        end
`endif
        mux_data_c = squash_c ? '0 : pick_c;
    end

    assign accept_c = in_valid & ~stall & ~flush;

    // Bubbles travel with squash forced low so out_squash only ever marks real beats.
    assign chain[0] = {in_valid, in_valid & squash_c, mux_data_c};

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .stall (stall),
            .flush (flush),
            .up    (chain[i]),
            .q     (chain[i+1])
        );
    end

    assign out_valid  = chain[DEPTH][WIDTH+1];
    assign out_squash = chain[DEPTH][WIDTH];
    assign out_data   = chain[DEPTH][WIDTH-1:0];

    // Clear wins over a coincident squash; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (cnt_clr) begin
            err_count <= '0;
        end else if (accept_c && squash_c && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_select_mux.sv
// Scoreboard bench for pipe_select_mux: main instance N=3/DEPTH=3/CNT_W=2, side instance N=4/DEPTH=1.
module tb_pipe_select_mux;
    import pipe_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 3;
    localparam int unsigned D  = 3;
    localparam int unsigned CW = 2;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [1:0]     sel;
    logic [N*W-1:0] data3;
    logic [4*W-1:0] data4;
    logic           stall;
    logic           flush;
    logic           cnt_clr;

    logic           out_valid;
    logic           out_squash;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  err_count;

    logic           v4;
    logic           sq4;
    logic [W-1:0]   d4;
    logic [7:0]     ec4;

    typedef struct {
        stage_t      beat;
        int unsigned tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned adv_cnt = 0;
    logic        mon_new = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cnt_m   = 0;

    pipe_select_mux #(
        .WIDTH(W), .N_INPUTS(N), .SEL_W(2), .DEPTH(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel), .data_in(data3),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_data(out_data), .out_squash(out_squash),
        .err_count(err_count)
    );

    pipe_select_mux #(
        .WIDTH(W), .N_INPUTS(4), .SEL_W(2), .DEPTH(1), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel), .data_in(data4),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(v4), .out_data(d4), .out_squash(sq4), .err_count(ec4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every edge that shifts the pipeline bumps adv_cnt; a beat's tag is the edge it must emerge on.
    always @(posedge clk) begin
        mon_new = rst_n && !stall && !flush;
        if (mon_new) adv_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && mon_new && out_valid) begin
            if (sb.size() == 0) begin
                check("sb_spurious", 64'(out_valid), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("sb_data",   64'(out_data),   64'(mon_e.beat.data));
                check("sb_squash", 64'(out_squash), 64'(mon_e.beat.squash));
                check("sb_tag",    64'(adv_cnt),    64'(mon_e.tag));
            end
        end
    end

    // Drive one cycle of inputs, predict the outcome, then check the counter after the edge.
    task automatic step(input logic v, input logic [1:0] s,
                        input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                        input logic st, input logic fl, input logic clr);
        logic [W-1:0] pick;
        logic         sq;
        exp_t         e;
        in_valid = v;
        sel      = s;
        data3    = {a2, a1, a0};
        data4    = {32'h4444_4444, a2, a1, a0};
        stall    = st;
        flush    = fl;
        cnt_clr  = clr;
        if (s == 2'd0)      pick = a0;
        else if (s == 2'd1) pick = a1;
        else                pick = a2;
        sq = (s == 2'd3) || $isunknown(pick);
        if (sq) pick = '0;
        if (v && !st && !fl) begin
            e.beat.valid  = 1'b1;
            e.beat.squash = sq;
            e.beat.data   = pick;
            e.tag         = adv_cnt + D;
            sb.push_back(e);
        end
        if (clr) cnt_m = 0;
        else if (v && !st && !fl && sq && cnt_m < 3) cnt_m++;
        @(posedge clk);
        #1;
        if (fl) sb.delete();
        check("err_count", 64'(err_count), 64'(cnt_m));
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name);
        bubbles(D + 1);
        check(name, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sel      = 2'd2;
        data3    = '1;
        data4    = '1;
        stall    = 1'b0;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  64'(out_valid),  64'(0));
        check("rst_data",   64'(out_data),   64'(0));
        check("rst_squash", 64'(out_squash), 64'(0));
        check("rst_count",  64'(err_count),  64'(0));
        check("rst1_valid", 64'(v4),         64'(0));
        check("rst1_data",  64'(d4),         64'(0));
        check("rst1_count", 64'(ec4),        64'(0));
        rst_n = 1'b1;

        // 1-cycle latency on the side instance, 3-cycle on the main one
        step(1'b1, 2'd2, 32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check("d1_valid",  64'(v4),  64'(1));
        check("d1_data",   64'(d4),  64'h0000_0000_DEAD_BEEF);
        check("d1_squash", 64'(sq4), 64'(0));
        drain("drain_t1");

        // ordered stream with a two-cycle stall in the middle
        step(1'b1, 2'd0, 32'hAAAA_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'h0, 32'hBBBB_0002, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'h0, 32'h0, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'hDDDD_0004, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'hDDDD_0004, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'hDDDD_0004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'h0, 32'hEEEE_0005, 32'h0, 1'b0, 1'b0, 1'b0);
        drain("drain_t2");

        // out-of-range select, X on the selected input, X only on an unselected input
        step(1'b1, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'h0, 32'hxxxx_xxxx, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'hxxxx_xxxx, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 1'b0);
        drain("drain_t3");

        // flush with stall and a squashing beat at the input
        step(1'b1, 2'd0, 32'h5555_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'h0, 32'h5555_0002, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("flush_valid", 64'(out_valid), 64'(0));
        drain("drain_t4");

        // saturation, stalled squash not counted, clear beats a coincident squash
        step(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd3, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0, 1'b0);
        check("stall_nocount", 64'(err_count), 64'(1));
        for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
        check("sat", 64'(err_count), 64'(3));
        step(1'b1, 2'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b1);
        check("clr_prio", 64'(err_count), 64'(0));
        drain("drain_t5");

        // asynchronous reset with the pipeline full
        step(1'b1, 2'd0, 32'h7777_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'h0, 32'h0, 32'h7777_0003, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  64'(out_valid),  64'(0));
        check("arst_data",   64'(out_data),   64'(0));
        check("arst_squash", 64'(out_squash), 64'(0));
        check("arst_count",  64'(err_count),  64'(0));
        sb.delete();
        cnt_m = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bubbles(D + 2);
        check("arst_drain", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
